// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one full cipher round per clock, round
// keys expanded on the fly from the previous round key. Valid/ready on both
// the plaintext and ciphertext sides; outputs decode registered state only.

// Forward S-box lookup. One instance per byte lane on the state and on the key word.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Table is listed from S(00) downwards, so entry for input a sits at index ~a.
  localparam logic [255:0][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  assign y = SBOX[~a];
endmodule

module aes128_encrypt_iter #(
  parameter int NR       = 10,  // only 10 is meaningful (AES-128)
  parameter int ZERO_OUT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] SecretKey,
  input  logic [127:0] PlainText,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] CipheredText
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   fsm;
  logic [3:0]   rnd;
  logic [127:0] state_reg, key_reg, nxt_state, nxt_key;
  logic         last_rnd;
  logic [7:0]   rcon;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [31:0]  rot_w, sub_w, kt, nk0, nk1, nk2, nk3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  assign last_rnd = (rnd == 4'(NR));

  // Round constant for the key step applied in the current round
  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Key schedule: w3 is key_reg[31:0]; RotWord, SubWord, Rcon, then XOR chain
  assign rot_w = {key_reg[23:0], key_reg[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_kb
    aes_sbox u_kb (.a(rot_w[31-8*j -: 8]), .y(sub_w[31-8*j -: 8]));
  end
  assign kt      = sub_w ^ {rcon, 24'h0};
  assign nk0     = key_reg[127:96] ^ kt;
  assign nk1     = key_reg[95:64]  ^ nk0;
  assign nk2     = key_reg[63:32]  ^ nk1;
  assign nk3     = key_reg[31:0]   ^ nk2;
  assign nxt_key = {nk0, nk1, nk2, nk3};

  // Byte i of the block is row i%4, column i/4
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (.a(state_reg[127-8*i -: 8]), .y(sb[i]));
    // ShiftRows: row r at column c takes the byte from column (c+r)%4
    assign sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] mix, col;
    assign a0  = sr[4*c];
    assign a1  = sr[4*c+1];
    assign a2  = sr[4*c+2];
    assign a3  = sr[4*c+3];
    assign mix = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    // Final round skips MixColumns
    assign col = last_rnd ? {a0, a1, a2, a3} : mix;
    assign nxt_state[127-32*c -: 32] = col ^ nxt_key[127-32*c -: 32];
  end

  // Control FSM plus state/key registers; one round per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_reg <= PlainText ^ SecretKey;
          key_reg   <= SecretKey;
          rnd       <= 4'd1;
          fsm       <= RUN;
        end
        RUN: begin
          state_reg <= nxt_state;
          key_reg   <= nxt_key;
          rnd       <= rnd + 4'd1;
          if (last_rnd) fsm <= DONE;
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready     = (fsm == IDLE);
  assign out_valid    = (fsm == DONE);
  assign CipheredText = ((ZERO_OUT != 0) && !out_valid) ? '0 : state_reg;
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: an AES-128 reference built from GF(2^8)
// arithmetic (S-box derived from inverse + affine map), a cycle-level
// handshake model, a per-cycle output comparator, and directed vectors.
module tb_aes128_encrypt_iter;
  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [127:0] SecretKey, PlainText, CipheredText;

  aes128_encrypt_iter #(.NR(10), .ZERO_OUT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SecretKey(SecretKey), .PlainText(PlainText), .out_valid(out_valid),
    .out_ready(out_ready), .CipheredText(CipheredText));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R2 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference cipher; stops after round nr (nr=10 gives the ciphertext)
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt, input int nr);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          if (r < 10)
            s[4*c+q] = gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03) ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
          else
            s[4*c+q] = t[4*c+q];
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Handshake model: idle / busy for 10 edges / holding a result
  int           m_left = 0;
  bit           m_done = 1'b0, chk_en = 1'b0;
  logic [127:0] m_res = '0;
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_res = '0; chk_en = 1'b1;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (in_valid) begin
      m_res  = aes_ref(SecretKey, PlainText, 10);
      m_left = 10;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready",  128'(in_ready),  128'(!m_done && m_left == 0));
      chk("out_valid", 128'(out_valid), 128'(m_done));
      chk("ct",        CipheredText,    m_done ? m_res : 128'h0);
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p, output int t_acc);
    int n;
    n = 0;
    SecretKey = k; PlainText = p; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo("send");
    @(posedge clk); #1;
    t_acc     = cyc;
    in_valid  = 1'b0;
    SecretKey = {$urandom, $urandom, $urandom, $urandom};
    PlainText = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int t_done);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) tmo("wait_out");
    t_done = cyc;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int ta, ta2, td, n;
  logic [127:0] kk, pp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Build S-box from the multiplicative inverse and the affine transform
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    // Pin the reference model to published values
    chk("model_sbox53", 128'(sbox_t[8'h53]), 128'hed);
    chk("model_c1",     aes_ref(K1, P1, 10), C1);
    chk("model_appb",   aes_ref(K2, P2, 10), C2);
    chk("model_appb_r1", aes_ref(K2, P2, 1), R2);
    chk("model_zero",   aes_ref('0, '0, 10), C0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; SecretKey = '0; PlainText = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_ct", CipheredText, 128'h0);

    // 1: FIPS-197 C.1 with latency
    send(K1, P1, ta); wait_out(td);
    chk("c1_latency", 128'(td - ta), 128'd10);
    chk("c1_ct", CipheredText, C1);
    take();

    // 2: App.B including the state after round 1
    send(K2, P2, ta);
    @(posedge clk); #1;
    chk("appb_round1", dut.state_reg, R2);
    wait_out(td);
    chk("appb_latency", 128'(td - ta), 128'd10);
    chk("appb_ct", CipheredText, C2);
    take();

    // 3: zero vector, 20 cycles of backpressure with in_valid pushing
    send('0, '0, ta); wait_out(td);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_ct", CipheredText, C0);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    take();

    // 4: in_valid held during RUN with other data; back-to-back spacing
    send(K1, P1, ta);
    SecretKey = K2; PlainText = P2; in_valid = 1'b1;
    wait_out(td);
    chk("b2b_first_ct", CipheredText, C1);
    take();
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    while (in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) tmo("b2b_accept");
    ta2 = cyc;
    in_valid = 1'b0;
    chk("b2b_period", 128'(ta2 - ta), 128'd12);
    wait_out(td);
    chk("b2b_second_ct", CipheredText, C2);
    take();

    // 5: reset in the middle of round processing
    send(K1, P1, ta);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_ct", CipheredText, 128'h0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_out", 128'(out_valid), 128'd0);
    end
    send(K2, P2, ta); wait_out(td);
    chk("midrst_appb_ct", CipheredText, C2);
    take();

    // 6: random key/plaintext pairs with random out_ready and gaps
    for (int k = 0; k < 100; k++) begin
      kk = {$urandom, $urandom, $urandom, $urandom};
      pp = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(kk, pp, ta); wait_out(td);
      chk("rnd_latency", 128'(td - ta), 128'd10);
      chk("rnd_ct", CipheredText, aes_ref(kk, pp, 10));
      take();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
